ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Multi-cycle RV32M divide responder for the EX stage.
- EX is the initiator. When it decodes DIV/DIVU/REM/REMU it issues a one-cycle request with its two operands and destination register.
- ex_div computes the result bit-serially and holds busy_o high so the pipeline control stalls IF/ID and ID/EX.
- When finished it returns result, destination register and write enable for one cycle, and EX forwards them to writeback.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  request strobe from EX, sampled only in IDLE
- op_i  input  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
- dividend_i  input  32  rs1 value
- divisor_i  input  32  rs2 value
- rd_addr_i  input  5  destination register of the request
- flush_i  input  1  pipeline flush (taken jump/branch); abandons the current operation
- result_o  output  32  quotient or remainder; valid only while ready_o=1
- ready_o  output  1  one-cycle result strobe
- rd_addr_o  output  5  destination register, valid with ready_o
- reg_wen_o  output  1  write enable for the result; equals ready_o
- busy_o  output  1  stall request to pipeline control

Behaviour:
- Reset: state=IDLE, count=0. All registered outputs are 0: result_o=0, ready_o=0, rd_addr_o=0, reg_wen_o=0. Reset wins over every other input, including mid-operation; no result is ever produced for an interrupted operation.
- States: IDLE, CALC, DONE.
- IDLE -> CALC: start_i=1 with a valid op_i and no special case.
  - Latch op, rd_addr and operand signs.
  - Latch |dividend| and |divisor| for signed ops, raw values for unsigned ops.
  - Clear the partial remainder; set count=0.
- IDLE -> DONE (special cases; result is precomputed at the start cycle):
  - Divisor == 0: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow, dividend = 0x80000000 and divisor = 0xFFFFFFFF (DIV/REM only): quotient = 0x80000000, remainder = 0.
- Invalid op_i (funct3[2]=0) with start_i=1 is ignored; stay in IDLE.
- CALC: one restoring-division step per cycle.
  - Shift the next dividend bit into the XLEN+1-bit partial remainder.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep the difference and shift 1 into the quotient; otherwise shift 0.
  - Increment count. After the XLEN-th step (count == XLEN-1 at the clock edge) go to DONE.
- Sign fix-up on entry to DONE, signed ops only:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- DONE lasts one cycle:
  - ready_o=1 and reg_wen_o=1.
  - result_o = quotient for DIV/DIVU, remainder for REM/REMU.
  - rd_addr_o = latched rd.
  - Next state is IDLE. All three outputs return to 0 the following cycle.
- Latency: start accepted at edge N. Normal ops: ready_o high in cycle N+33 (XLEN+1 cycles after the start cycle). Special cases: ready_o high in cycle N+1.
- busy_o (combinational) = (IDLE & start_i & valid op) | CALC.
  - busy_o is low in DONE so the stalled instruction advances while the result retires.
  - The result therefore writes rd no earlier than the next instruction's register read.
- start_i while in CALC or DONE is ignored; EX must not re-request until it sees ready_o.
- start_i in the same cycle as DONE (back-to-back divides) is ignored; it is accepted on the next IDLE cycle.
- flush_i=1 in any state:
  - Go to IDLE next edge with ready_o=0 and no write.
  - A flush in DONE suppresses ready_o in that same cycle (ready_o and reg_wen_o are gated by !flush_i).
  - start_i and flush_i together in IDLE: the flush wins and no operation starts.
- Quotient register, partial remainder and count are not reset-cleared beyond count=0; they are don't-care outside CALC/DONE.

Test Plan:
- DIVU 100/7: start at edge N -> busy_o=1 for cycles N..N+32; ready_o=1, result_o=14, rd_addr_o=rd, reg_wen_o=1 in cycle N+33 only.
- Signed, dividend=-20 (0xFFFFFFEC), divisor=3: DIV -> 0xFFFFFFFA (-6); REM -> 0xFFFFFFFE (-2). REMU 0xFFFFFFEC/3 -> 2.
- Divide by zero 5/0: DIVU -> 0xFFFFFFFF; REMU -> 5; both with ready_o in cycle N+1.
- Overflow 0x80000000 / 0xFFFFFFFF: DIV -> 0x80000000; REM -> 0; ready_o in cycle N+1. DIVU of the same operands -> 0 after 33 cycles.
- flush_i pulsed at cycle N+10 of a DIVU -> state IDLE at N+11, busy_o=0, ready_o never asserted. A new DIVU 9/3 started at N+12 -> result 3 at N+45.
- rst asserted at cycle N+20 of an operation -> all outputs 0 the next cycle, no ready_o. start_i during rst is ignored. A back-to-back start in the DONE cycle is ignored and accepted the following cycle.

Source files
------------

// File: rtl/ex_div_if.sv
// Request/response bundle between the EX stage (master) and the divide unit (slave).
interface ex_div_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic [XLEN-1:0] result_o;
    logic            ready_o;
    logic [4:0]      rd_addr_o;
    logic            reg_wen_o;
    logic            busy_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
        input  result_o, ready_o, rd_addr_o, reg_wen_o, busy_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
        output result_o, ready_o, rd_addr_o, reg_wen_o, busy_o
    );
endinterface

// File: rtl/ex_div.sv
// Bit-serial RV32M divider (DIV/DIVU/REM/REMU): one restoring step per cycle,
// with divide-by-zero and signed overflow resolved in the start cycle.
module ex_div #(
    parameter int unsigned XLEN = 32
) (
    input  logic      clk,
    input  logic      rst,
    ex_div_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [XLEN-1:0]     quo_q, quo_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     dvs_q, dvs_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          rd_q, rd_d;
    logic                is_rem_q, is_rem_d;
    logic                negq_q, negq_d;
    logic                negr_q, negr_d;

    logic                valid_op, is_signed, is_rem;
    logic                dvd_neg, dvs_neg;
    logic [XLEN-1:0]     dvd_abs, dvs_abs;
    logic [XLEN:0]       rem_shift, diff;
    logic [XLEN-1:0]     q_next, r_next;
    logic [XLEN-1:0]     q_fix, r_fix;

    assign valid_op  = bus.op_i[2];
    assign is_signed = ~bus.op_i[0];
    assign is_rem    = bus.op_i[1];
    assign dvd_neg   = is_signed & bus.dividend_i[XLEN-1];
    assign dvs_neg   = is_signed & bus.divisor_i[XLEN-1];
    assign dvd_abs   = dvd_neg ? -bus.dividend_i : bus.dividend_i;
    assign dvs_abs   = dvs_neg ? -bus.divisor_i  : bus.divisor_i;

    // The dividend shifts out of quo_q's MSB while quotient bits fill its LSB.
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};
    assign q_next    = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign r_next    = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
    assign q_fix     = negq_q ? -q_next : q_next;
    assign r_fix     = negr_q ? -r_next : r_next;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        rd_d     = rd_q;
        is_rem_d = is_rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i && valid_op && !bus.flush_i) begin
                    rd_d     = bus.rd_addr_i;
                    is_rem_d = is_rem;
                    if (bus.divisor_i == '0) begin
                        result_d = is_rem ? bus.dividend_i : '1;
                        state_d  = DONE;
                    end else if (is_signed && bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}}
                                 && bus.divisor_i == '1) begin
                        result_d = is_rem ? '0 : bus.dividend_i;
                        state_d  = DONE;
                    end else begin
                        quo_d   = dvd_abs;
                        dvs_d   = dvs_abs;
                        rem_d   = '0;
                        count_d = '0;
                        negq_d  = dvd_neg ^ dvs_neg;
                        negr_d  = dvd_neg;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                quo_d   = q_next;
                rem_d   = r_next;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(XLEN - 1)) begin
                    result_d = is_rem_q ? r_fix : q_fix;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        quo_q    <= quo_d;
        rem_q    <= rem_d;
        dvs_q    <= dvs_d;
        is_rem_q <= is_rem_d;
        negq_q   <= negq_d;
        negr_q   <= negr_d;
    end

    assign bus.ready_o   = (state_q == DONE) && !bus.flush_i;
    assign bus.reg_wen_o = bus.ready_o;
    assign bus.result_o  = (state_q == DONE) ? result_q : '0;
    assign bus.rd_addr_o = (state_q == DONE) ? rd_q : '0;
    assign bus.busy_o    = ((state_q == IDLE) && bus.start_i && valid_op) || (state_q == CALC);
endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: driver pushes reference results, monitor pops on ready_o.
module tb_ex_div;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_div_if #(.XLEN(32)) bus();
    ex_div #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference semantics straight from the RISC-V M rules.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sbv;
        logic ovf;
        sa  = a;
        sbv = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sbv));
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sbv));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic is_signed_op;
        is_signed_op = (op == 3'b100) || (op == 3'b110);
        if (b == 0 || (is_signed_op && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return 32'($urandom >> $urandom_range(0, 31));
        endcase
    endfunction

    // Monitor: samples after the driver's negedge updates have settled.
    always begin
        @(negedge clk);
        #2;
        if (bus.ready_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(bus.ready_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", bus.result_o, e.res);
                check("rd_addr", 32'(bus.rd_addr_o), 32'(e.rd));
                check("reg_wen", 32'(bus.reg_wen_o), 32'd1);
                check("latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Caller is at a negedge; request is held for exactly this cycle.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input bit expect_it);
        bus.start_i    = 1'b1;
        bus.op_i       = op;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.rd_addr_i  = rd;
        if (expect_it && op[2]) sb.push_back('{res: ref_res(op, a, b), rd: rd, due: cyc + ref_lat(op, a, b)});
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        start_op(op, a, b, rd, 1'b1);
        repeat (ref_lat(op, a, b)) @(negedge clk);
    endtask

    initial begin
        int nb;
        bus.start_i    = 1'b0;
        bus.op_i       = 3'b000;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.rd_addr_i  = '0;
        bus.flush_i    = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready_o), 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        check("rst_rd", 32'(bus.rd_addr_o), 32'd0);
        check("rst_wen", 32'(bus.reg_wen_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // DIVU 100/7 with busy profile
        start_op(3'b101, 32'd100, 32'd7, 5'd3, 1'b1);
        nb = 0;
        for (int i = 1; i <= 32; i++) begin
            if (bus.busy_o === 1'b1) nb++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(nb), 32'd32);
        #1 check("busy_in_done", 32'(bus.busy_o), 32'd0);
        @(negedge clk);

        run_op(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd4);
        run_op(3'b110, 32'hFFFF_FFEC, 32'd3, 5'd5);
        run_op(3'b111, 32'hFFFF_FFEC, 32'd3, 5'd6);
        run_op(3'b101, 32'd5, 32'd0, 5'd7);
        run_op(3'b111, 32'd5, 32'd0, 5'd8);
        run_op(3'b100, 32'd5, 32'd0, 5'd9);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

        // Randomised mix including invalid funct3 values
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            logic [4:0]  rd;
            op = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            rd = 5'($urandom_range(0, 31));
            if (op[2]) begin
                run_op(op, a, b, rd);
            end else begin
                start_op(op, a, b, rd, 1'b0);
                check("invalid_op_busy", 32'(bus.busy_o), 32'd0);
            end
        end

        // Flush mid-operation, then a fresh DIVU 9/3 two cycles later
        start_op(3'b101, 32'd1000, 32'd7, 5'd13, 1'b0);
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1 check("flush_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
        run_op(3'b101, 32'd9, 32'd3, 5'd14);

        // Reset mid-operation with start_i held during reset
        start_op(3'b100, 32'd12345, 32'd17, 5'd15, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        bus.start_i = 1'b1;
        bus.op_i = 3'b101;
        bus.dividend_i = 32'd50;
        bus.divisor_i = 32'd5;
        @(negedge clk);
        #1;
        check("midrst_ready", 32'(bus.ready_o), 32'd0);
        check("midrst_result", bus.result_o, 32'd0);
        check("midrst_rd", 32'(bus.rd_addr_o), 32'd0);
        check("midrst_wen", 32'(bus.reg_wen_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        #1 check("postrst_busy", 32'(bus.busy_o), 32'd0);
        repeat (40) @(negedge clk);

        // Back-to-back: start during DONE is ignored, accepted next IDLE cycle
        start_op(3'b101, 32'd77, 32'd5, 5'd16, 1'b1);
        repeat (32) @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i = 3'b111;
        bus.dividend_i = 32'd77;
        bus.divisor_i = 32'd6;
        bus.rd_addr_i = 5'd17;
        sb.push_back('{res: ref_res(3'b111, 32'd77, 32'd6), rd: 5'd17, due: cyc + 1 + 33});
        @(negedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (33) @(negedge clk);

        // Flush in DONE suppresses the result strobe
        start_op(3'b111, 32'd100, 32'd9, 5'd18, 1'b0);
        repeat (32) @(negedge clk);
        bus.flush_i = 1'b1;
        #1 check("flush_done_ready", 32'(bus.ready_o), 32'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;

        // Flush together with start in IDLE: nothing starts
        bus.flush_i = 1'b1;
        bus.start_i = 1'b1;
        bus.op_i = 3'b101;
        bus.divisor_i = 32'd0;
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        #1 check("flush_start_busy", 32'(bus.busy_o), 32'd0);
        repeat (40) @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
